// File: rtl/sdrc_wb_arb_if.sv
// Bus bundle between the Wishbone masters, the arbiter and the wb2sdrc slave port.
// The arbiter binds to modport slave; the surrounding environment uses modport master.
interface sdrc_wb_arb_if #(
  parameter int NPORT = 4,
  parameter int dw    = 32,
  parameter int AW    = 25
);
  logic [NPORT-1:0]        m_wb_cyc_i;
  logic [NPORT-1:0]        m_wb_stb_i;
  logic [NPORT-1:0]        m_wb_we_i;
  logic [NPORT*AW-1:0]     m_wb_addr_i;
  logic [NPORT*dw-1:0]     m_wb_dat_i;
  logic [NPORT*dw/8-1:0]   m_wb_sel_i;
  logic [NPORT*3-1:0]      m_wb_cti_i;
  logic [NPORT-1:0]        m_wb_ack_o;
  logic [NPORT*dw-1:0]     m_wb_dat_o;

  logic                    s_wb_cyc_o;
  logic                    s_wb_stb_o;
  logic                    s_wb_we_o;
  logic [AW-1:0]           s_wb_addr_o;
  logic [dw-1:0]           s_wb_dat_o;
  logic [dw/8-1:0]         s_wb_sel_o;
  logic [2:0]              s_wb_cti_o;
  logic                    s_wb_ack_i;
  logic [dw-1:0]           s_wb_dat_i;

  logic [NPORT-1:0]        arb_gnt_o;

  modport slave (
    input  m_wb_cyc_i, m_wb_stb_i, m_wb_we_i, m_wb_addr_i, m_wb_dat_i, m_wb_sel_i, m_wb_cti_i,
    output m_wb_ack_o, m_wb_dat_o,
    output s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, s_wb_addr_o, s_wb_dat_o, s_wb_sel_o, s_wb_cti_o,
    input  s_wb_ack_i, s_wb_dat_i,
    output arb_gnt_o
  );

  modport master (
    output m_wb_cyc_i, m_wb_stb_i, m_wb_we_i, m_wb_addr_i, m_wb_dat_i, m_wb_sel_i, m_wb_cti_i,
    input  m_wb_ack_o, m_wb_dat_o,
    input  s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, s_wb_addr_o, s_wb_dat_o, s_wb_sel_o, s_wb_cti_o,
    output s_wb_ack_i, s_wb_dat_i,
    input  arb_gnt_o
  );
endinterface

// File: rtl/sdrc_wb_arb.sv
// NPORT-way Wishbone arbiter in front of wb2sdrc: round-robin with a beat-count fairness
// release by default; define SDRC_WB_ARB_PRIO_EN for fixed priority without fairness release.
//
//   state    | meaning
//   ST_IDLE  | no owner; any cyc is arbitrated and the winner is granted on the next edge
//   ST_OWN   | granted port drives the slave; acks and read data routed back to it
//   ST_GAP   | one dead cycle with s_wb_cyc_o low before re-arbitration
module sdrc_wb_arb #(
  parameter int NPORT       = 4,
  parameter int dw          = 32,
  parameter int AW          = 25,
  parameter int BURST_LIMIT = 16
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  sdrc_wb_arb_if.slave   bus
);

  localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int SW = dw / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [NPORT-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    last_q, last_d;
  logic [7:0]       cnt_q, cnt_d;

  logic [IW-1:0]    sel_idx;
  logic             sel_found;
  logic             own;
  logic             any_req;
  logic             others_req;
  logic             cyc_g;
  logic [2:0]       cti_g;
  logic             fair_rel;

  assign own        = (state_q == ST_OWN);
  assign any_req    = |bus.m_wb_cyc_i;
  assign cyc_g      = bus.m_wb_cyc_i[idx_q];
  assign cti_g      = bus.m_wb_cti_i[idx_q*3 +: 3];
  assign others_req = |(bus.m_wb_cyc_i & ~gnt_q);

`ifdef SDRC_WB_ARB_PRIO_EN
  assign fair_rel = 1'b0;

  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      if (!sel_found && bus.m_wb_cyc_i[i]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end
`else
  // Only release on a beat boundary that cannot be inside an incrementing burst.
  assign fair_rel = bus.s_wb_ack_i
                 && ((cti_g == 3'b000) || (cti_g == 3'b111))
                 && (({1'b0, cnt_q} + 9'd1) >= 9'(BURST_LIMIT))
                 && others_req;

  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = 1; i <= NPORT; i++) begin
      if (!sel_found && bus.m_wb_cyc_i[(int'(last_q) + i) % NPORT]) begin
        sel_found = 1'b1;
        sel_idx   = IW'((int'(last_q) + i) % NPORT);
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_OWN;
          idx_d   = sel_idx;
          gnt_d   = NPORT'(1) << sel_idx;
          cnt_d   = '0;
        end
      end
      ST_OWN: begin
        if (bus.s_wb_ack_i && (cnt_q != 8'hFF)) begin
          cnt_d = cnt_q + 8'd1;
        end
        if (!cyc_g || fair_rel) begin
          state_d = ST_GAP;
          gnt_d   = '0;
          last_d  = idx_q;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= IW'(NPORT - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Everything below is gated by ownership, so reset (which forces IDLE) silences all outputs.
  always_comb begin
    bus.s_wb_cyc_o  = 1'b0;
    bus.s_wb_stb_o  = 1'b0;
    bus.s_wb_we_o   = 1'b0;
    bus.s_wb_addr_o = '0;
    bus.s_wb_dat_o  = '0;
    bus.s_wb_sel_o  = '0;
    bus.s_wb_cti_o  = '0;
    if (own) begin
      bus.s_wb_cyc_o  = cyc_g;
      bus.s_wb_stb_o  = bus.m_wb_stb_i[idx_q];
      bus.s_wb_we_o   = bus.m_wb_we_i[idx_q];
      bus.s_wb_addr_o = bus.m_wb_addr_i[idx_q*AW +: AW];
      bus.s_wb_dat_o  = bus.m_wb_dat_i[idx_q*dw +: dw];
      bus.s_wb_sel_o  = bus.m_wb_sel_i[idx_q*SW +: SW];
      bus.s_wb_cti_o  = cti_g;
    end
  end

  always_comb begin
    bus.m_wb_ack_o = '0;
    bus.m_wb_dat_o = '0;
    if (own) begin
      bus.m_wb_ack_o[idx_q]          = bus.s_wb_ack_i;
      bus.m_wb_dat_o[idx_q*dw +: dw] = bus.s_wb_dat_i;
    end
  end

  assign bus.arb_gnt_o = gnt_q;

endmodule

// File: tb/tb_sdrc_wb_arb.sv
// Self-checking bench for sdrc_wb_arb (default round-robin build): directed scenarios plus
// randomized traffic compared every cycle against a tenure-level reference model.
module tb_sdrc_wb_arb;
  localparam int NP = 4;
  localparam int DW = 32;
  localparam int AW = 25;
  localparam int BL = 4;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdrc_wb_arb_if #(.NPORT(NP), .dw(DW), .AW(AW)) bus ();

  sdrc_wb_arb #(.NPORT(NP), .dw(DW), .AW(AW), .BURST_LIMIT(BL)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the slave, whether we sit in the dead cycle, fairness history.
  int owner;
  bit in_gap;
  int last_owner;
  int beats;

  logic [NP-1:0] obs_gnt;
  logic [NP-1:0] obs_ack;

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    owner      = -1;
    in_gap     = 1'b0;
    last_owner = NP - 1;
    beats      = 0;
  endtask

  task automatic clear_inputs();
    bus.m_wb_cyc_i  = '0;
    bus.m_wb_stb_i  = '0;
    bus.m_wb_we_i   = '0;
    bus.m_wb_addr_i = '0;
    bus.m_wb_dat_i  = '0;
    bus.m_wb_sel_i  = '0;
    bus.m_wb_cti_i  = '0;
    bus.s_wb_ack_i  = 1'b0;
    bus.s_wb_dat_i  = '0;
  endtask

  task automatic set_port(input int p, input bit c, input logic [2:0] cti);
    bus.m_wb_cyc_i[p]           = c;
    bus.m_wb_stb_i[p]           = c;
    bus.m_wb_we_i[p]            = 1'($urandom);
    bus.m_wb_cti_i[p*3 +: 3]    = cti;
    bus.m_wb_addr_i[p*AW +: AW] = AW'($urandom);
    bus.m_wb_dat_i[p*DW +: DW]  = $urandom;
    bus.m_wb_sel_i[p*SW +: SW]  = SW'($urandom);
  endtask

  task automatic check_outputs();
    logic [NP-1:0]    eg;
    logic [NP-1:0]    ea;
    logic [NP*DW-1:0] ed;
    logic [66:0]      es;
    logic [66:0]      os;
    eg = '0;
    ea = '0;
    ed = '0;
    es = '0;
    if (owner >= 0) begin
      eg[owner] = 1'b1;
      ea[owner] = bus.s_wb_ack_i;
      ed[owner*DW +: DW] = bus.s_wb_dat_i;
      es = {bus.m_wb_cyc_i[owner], bus.m_wb_stb_i[owner], bus.m_wb_we_i[owner],
            bus.m_wb_addr_i[owner*AW +: AW], bus.m_wb_dat_i[owner*DW +: DW],
            bus.m_wb_sel_i[owner*SW +: SW], bus.m_wb_cti_i[owner*3 +: 3]};
    end
    os = {bus.s_wb_cyc_o, bus.s_wb_stb_o, bus.s_wb_we_o, bus.s_wb_addr_o,
          bus.s_wb_dat_o, bus.s_wb_sel_o, bus.s_wb_cti_o};
    chk("gnt", bus.arb_gnt_o, eg);
    chk("s_req", os, es);
    chk("m_ack", bus.m_wb_ack_o, ea);
    chk("m_dat", bus.m_wb_dat_o, ed);
    obs_gnt = bus.arb_gnt_o;
    obs_ack = bus.m_wb_ack_o;
  endtask

  // Advance the model over one clock edge using the inputs present just before it.
  task automatic model_edge();
    logic [2:0] cti;
    bit others;
    bit found;
    int p;
    if (in_gap) begin
      in_gap = 1'b0;
    end else if (owner < 0) begin
      found = 1'b0;
      for (int i = 1; i <= NP; i++) begin
        p = (last_owner + i) % NP;
        if (!found && bus.m_wb_cyc_i[p]) begin
          found = 1'b1;
          owner = p;
          beats = 0;
        end
      end
    end else begin
      cti    = bus.m_wb_cti_i[owner*3 +: 3];
      others = 1'b0;
      for (int i = 0; i < NP; i++) if (i != owner && bus.m_wb_cyc_i[i]) others = 1'b1;
      if (!bus.m_wb_cyc_i[owner] ||
          (bus.s_wb_ack_i && (cti == 3'b000 || cti == 3'b111) && beats + 1 >= BL && others)) begin
        last_owner = owner;
        owner      = -1;
        in_gap     = 1'b1;
      end else if (bus.s_wb_ack_i && beats < 255) begin
        beats++;
      end
    end
  endtask

  task automatic step();
    #1;
    check_outputs();
    if (rst) model_reset();
    else model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int            tq[$];
  int            ta[$];
  int            stray;
  logic [NP-1:0] cur;
  int            nbeats;
  bit            moved;
  int            at_move;
  bit            c;
  logic [2:0]    rcti;

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();
    @(posedge clk);
    #1;
    // Requests and a slave ack while in reset must not leak to any output.
    bus.m_wb_cyc_i = '1;
    bus.m_wb_stb_i = '1;
    bus.s_wb_ack_i = 1'b1;
    bus.s_wb_dat_i = 32'hDEAD_BEEF;
    #1;
    check_outputs();
    do_reset();

    // Simultaneous requests from 0 and 2, then handover through the gap.
    set_port(0, 1'b1, 3'b000);
    set_port(2, 1'b1, 3'b000);
    step();
    chk("sim_gnt0", bus.arb_gnt_o, 4'b0001);
    set_port(0, 1'b0, 3'b000);
    step();
    chk("gap_gnt", bus.arb_gnt_o, 4'b0000);
    chk("gap_cyc", bus.s_wb_cyc_o, 1'b0);
    step();
    chk("idle_gnt", bus.arb_gnt_o, 4'b0000);
    step();
    chk("sim_gnt2", bus.arb_gnt_o, 4'b0100);
    step();

    // Two hogging single-beat masters alternate every BL acks.
    do_reset();
    set_port(1, 1'b1, 3'b000);
    set_port(3, 1'b1, 3'b000);
    bus.s_wb_ack_i = 1'b1;
    cur = '0;
    stray = 0;
    for (int n = 0; n < 30; n++) begin
      step();
      if (obs_gnt != '0) begin
        if (obs_gnt != cur) begin
          tq.push_back(int'(obs_gnt));
          ta.push_back(0);
          cur = obs_gnt;
        end
        ta[ta.size()-1] += $countones(obs_ack & obs_gnt);
      end
      stray += $countones(obs_ack & ~obs_gnt);
    end
    for (int i = 0; i < 4; i++) chk("rr_order", (i < tq.size()) ? tq[i] : 0, (i % 2 == 0) ? 2 : 8);
    for (int i = 0; i < 3; i++) chk("rr_acks", (i < ta.size()) ? ta[i] : 0, 4);
    chk("rr_stray", stray, 0);

    // An 8-beat incrementing burst is never cut by the fairness release.
    do_reset();
    set_port(2, 1'b1, 3'b010);
    step();
    chk("burst_gnt", bus.arb_gnt_o, 4'b0100);
    set_port(0, 1'b1, 3'b000);
    bus.s_wb_ack_i = 1'b1;
    nbeats  = 0;
    moved   = 1'b0;
    at_move = -1;
    for (int n = 0; n < 20; n++) begin
      if (!moved) begin
        bus.m_wb_cti_i[2*3 +: 3] = (nbeats >= 7) ? 3'b111 : 3'b010;
        step();
        nbeats += int'(obs_ack[2]);
        if (bus.arb_gnt_o == 4'b0001) begin
          moved   = 1'b1;
          at_move = nbeats;
        end
      end
    end
    chk("burst_beats", at_move, 8);

    // Read data lands only on the granted port.
    do_reset();
    set_port(1, 1'b1, 3'b000);
    step();
    bus.s_wb_dat_i = 32'hA5A5_1234;
    bus.s_wb_ack_i = 1'b1;
    #1;
    chk("rd_dat", bus.m_wb_dat_o, 128'h00000000_00000000_A5A51234_00000000);
    step();

    // Reset in the middle of an acked beat: outputs drop at once, port 0 wins afterwards.
    set_port(0, 1'b1, 3'b000);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_ack", bus.m_wb_ack_o, 4'b0000);
    chk("rst_cyc", bus.s_wb_cyc_o, 1'b0);
    chk("rst_gnt", bus.arb_gnt_o, 4'b0000);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("rst_first", bus.arb_gnt_o, 4'b0001);
    step();

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      for (int p = 0; p < NP; p++) begin
        c = bus.m_wb_cyc_i[p];
        if ($urandom_range(0, 7) == 0) c = ~c;
        case ($urandom_range(0, 3))
          0, 1:    rcti = 3'b000;
          2:       rcti = 3'b010;
          default: rcti = 3'b111;
        endcase
        set_port(p, c, rcti);
      end
      bus.s_wb_ack_i = 1'($urandom_range(0, 1));
      bus.s_wb_dat_i = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
